// File: rtl/micro_pkg.sv
// Shared widths and the write-back FIFO entry layout
// used by the write-back sequencer.
package micro_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              killed;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/escritura_registros.sv
// Write-back sequencer: merges ALU and load results
// into the single register-file write port.
module escritura_registros
  import micro_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = micro_pkg::DATA_W,
  parameter int ADDR_W = micro_pkg::ADDR_W,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              flush,
  input  logic [ADDR_W-1:0] chk_reg,
  output logic              chk_busy,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              RegWrite,
  output logic [CW-1:0]     count
);

  wb_entry_t        r_fifo [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;

  logic             w_alu_wr;
  logic             w_push;
  logic             w_store;
  logic             w_pop;
  wb_entry_t        w_head;

  assign mem_ready = (count < CW'(DEPTH));
  assign w_alu_wr  = alu_valid && (alu_rd != '0);
  assign w_push    = mem_valid && mem_ready && !flush;
  assign w_store   = w_push && (mem_rd != '0);
  assign w_pop     = !w_alu_wr && (count != '0) && !flush;
  assign w_head    = r_fifo[r_rd_ptr];

  // Hazard query: any live, unkilled entry aimed at chk_reg
  always_comb begin
    chk_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) &&
          !r_fifo[r_rd_ptr + PW'(i)].killed &&
          (r_fifo[r_rd_ptr + PW'(i)].rd == chk_reg))
        chk_busy = 1'b1;
    end
    if (chk_reg == '0)
      chk_busy = 1'b0;
  end

  // Output selection, kill marking and FIFO bookkeeping
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      RegWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      count     <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_fifo[i] <= '0;
    end else begin
      RegWrite <= 1'b0;
      if (w_alu_wr) begin
        RegWrite  <= 1'b1;
        writeReg  <= alu_rd;
        writeData <= alu_data;
        // Older loads to the same rd must not overwrite this
        for (int i = 0; i < DEPTH; i++)
          if (r_fifo[i].rd == alu_rd)
            r_fifo[i].killed <= 1'b1;
      end else if (w_pop && !w_head.killed) begin
        RegWrite  <= 1'b1;
        writeReg  <= w_head.rd;
        writeData <= w_head.data;
      end

      if (flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        count    <= '0;
      end else begin
        // Later assignment: a fresh push is never killed
        if (w_store) begin
          r_fifo[r_wr_ptr] <= '{killed: 1'b0,
                                rd:     mem_rd,
                                data:   mem_data};
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + 1'b1;
        count <= count + CW'(w_store) - CW'(w_pop);
      end
    end
  end

endmodule

// File: tb/tb_escritura_registros.sv
// Directed vector bench for the write-back sequencer
// with a register-file model on its write port.
module tb_escritura_registros;

  logic        CLK;
  logic        RESET_N;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        flush;
  logic [4:0]  chk_reg;
  logic        chk_busy;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        RegWrite;
  logic [2:0]  count;

  int vecs;
  int miss;
  int x0_writes;
  logic [31:0] rf [32];

  escritura_registros dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .flush     (flush),
    .chk_reg   (chk_reg),
    .chk_busy  (chk_busy),
    .writeReg  (writeReg),
    .writeData (writeData),
    .RegWrite  (RegWrite),
    .count     (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (RegWrite) begin
      if (writeReg == 5'd0) x0_writes <= x0_writes + 1;
      else rf[writeReg] <= writeData;
    end
  end

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        fl;
    logic [4:0]  ck;
    logic        e_rw;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic [2:0]  e_cnt;
    logic        e_rdy;
    logic        e_busy;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard,
    input logic [31:0] ad, input logic mv,
    input logic [4:0] mrd, input logic [31:0] md,
    input logic fl, input logic [4:0] ck,
    input logic rw, input logic [4:0] wr,
    input logic [31:0] wd, input logic [2:0] cnt,
    input logic rdy, input logic busy);
    vec_t r;
    r.av = av; r.ard = ard; r.ad = ad;
    r.mv = mv; r.mrd = mrd; r.md = md;
    r.fl = fl; r.ck = ck;
    r.e_rw = rw; r.e_wr = wr; r.e_wd = wd;
    r.e_cnt = cnt; r.e_rdy = rdy; r.e_busy = busy;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
    mem_valid = v.mv; mem_rd = v.mrd; mem_data = v.md;
    flush = v.fl; chk_reg = v.ck;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    flush = 0; chk_reg = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vecs = 0;
    miss = 0;
    x0_writes = 0;
    idle();

    // reset/ALU/x0 drops
    tbl[0]  = mk(1,5,32'hA1,0,0,0,0,0, 1,5,32'hA1,0,1,0);
    tbl[1]  = mk(1,0,32'hFFFF_FFFF,0,0,0,0,0,
                 0,5,32'hA1,0,1,0);
    tbl[2]  = mk(0,0,0,1,0,32'h55,0,0, 0,5,32'hA1,0,1,0);
    // fill under ALU starvation
    tbl[3]  = mk(1,20,100,1,1,10,0,1, 1,20,100,1,1,1);
    tbl[4]  = mk(1,21,101,1,2,11,0,2, 1,21,101,2,1,1);
    tbl[5]  = mk(1,22,102,1,3,12,0,3, 1,22,102,3,1,1);
    tbl[6]  = mk(1,23,103,1,4,13,0,4, 1,23,103,4,0,1);
    tbl[7]  = mk(1,24,104,1,5,14,0,5, 1,24,104,4,0,0);
    // drain in order
    tbl[8]  = mk(0,0,0,0,0,0,0,1, 1,1,10,3,1,0);
    tbl[9]  = mk(0,0,0,0,0,0,0,2, 1,2,11,2,1,0);
    tbl[10] = mk(0,0,0,0,0,0,0,4, 1,3,12,1,1,1);
    tbl[11] = mk(0,0,0,0,0,0,0,4, 1,4,13,0,1,0);
    tbl[12] = mk(0,0,0,0,0,0,0,0, 0,4,13,0,1,0);
    // kill
    tbl[13] = mk(0,0,0,1,7,32'h1111,0,7,
                 0,4,13,1,1,1);
    tbl[14] = mk(1,7,32'h2222,0,0,0,0,7,
                 1,7,32'h2222,1,1,0);
    tbl[15] = mk(0,0,0,0,0,0,0,7, 0,7,32'h2222,0,1,0);
    // flush
    tbl[16] = mk(1,30,1,1,1,21,0,1, 1,30,1,1,1,1);
    tbl[17] = mk(1,31,2,1,2,22,0,1, 1,31,2,2,1,1);
    tbl[18] = mk(1,29,3,1,3,23,0,3, 1,29,3,3,1,1);
    tbl[19] = mk(1,9,99,1,4,24,1,1, 1,9,99,0,1,0);
    tbl[20] = mk(0,0,0,0,0,0,0,1, 0,9,99,0,1,0);
    tbl[21] = mk(0,0,0,0,0,0,0,4, 0,9,99,0,1,0);

    RESET_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rw",    32'(RegWrite), 32'd0);
    chk("rst_wreg",  32'(writeReg), 32'd0);
    chk("rst_wdata", writeData,     32'd0);
    chk("rst_count", 32'(count),    32'd0);
    chk("rst_ready", 32'(mem_ready), 32'd1);
    RESET_N = 1'b1;

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i]);
      tick();
      chk($sformatf("v%0d_rw", i),
          32'(RegWrite), 32'(tbl[i].e_rw));
      chk($sformatf("v%0d_wreg", i),
          32'(writeReg), 32'(tbl[i].e_wr));
      chk($sformatf("v%0d_wdata", i),
          writeData, tbl[i].e_wd);
      chk($sformatf("v%0d_count", i),
          32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("v%0d_ready", i),
          32'(mem_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_busy", i),
          32'(chk_busy), 32'(tbl[i].e_busy));
      if (i == 15)
        chk("rf_x7", rf[7], 32'h2222);
    end

    chk("rf_x0", rf[0], 32'd0);
    chk("x0_writes", 32'(x0_writes), 32'd0);
    chk("rf_x4", rf[4], 32'd13);
    chk("rf_x9", rf[9], 32'd99);
    chk("rf_x1_not_flushed", rf[1], 32'd10);

    // queue two loads, then async reset between edges
    alu_valid = 1; alu_rd = 25; alu_data = 32'h25;
    mem_valid = 1; mem_rd = 10; mem_data = 32'hAA;
    tick();
    alu_rd = 26; alu_data = 32'h26;
    mem_rd = 11; mem_data = 32'hBB;
    tick();
    chk("pre_rst_count", 32'(count), 32'd2);
    chk("pre_rst_rw", 32'(RegWrite), 32'd1);
    idle();
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst_rw",    32'(RegWrite),  32'd0);
    chk("arst_wreg",  32'(writeReg),  32'd0);
    chk("arst_wdata", writeData,      32'd0);
    chk("arst_count", 32'(count),     32'd0);
    chk("arst_ready", 32'(mem_ready), 32'd1);
    RESET_N = 1'b1;
    tick();
    chk("post_rst_rw", 32'(RegWrite), 32'd0);
    tick();
    chk("post_rst_rw2", 32'(RegWrite), 32'd0);
    chk("post_rst_count", 32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule
